pbus_master: RTL and testbench

PBUS_MASTER -- requirements
Module: pbus_master

---
 rtl/pbus_pkg.sv | 18 +
 rtl/pbus_sync.sv | 24 ++
 rtl/pbus_master.sv | 166 ++++++++++++++++
 tb/tb_pbus_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pbus_pkg.sv
// Shared types and constants for the parallel-bus master: bus widths,
// the default strobe timeout and the transfer FSM state encoding.
package pbus_pkg;

  localparam int PBUS_ADDR_W          = 15;
  localparam int PBUS_DATA_W          = 32;
  localparam int PBUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE,
    ST_RESP
  } pbus_state_e;

endpackage

// File: rtl/pbus_sync.sv
// Multi-flop synchronizer for a single asynchronous level; every stage
// resets to 1 so an idle active-low input reads as deasserted.
module pbus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstN_i,
  input  logic data_i,
  output logic data_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], data_i};
    end
  end

  assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/pbus_master.sv
// Single-outstanding-command master for an asynchronous strobe/ready
// parallel bus, with a strobe timeout and a one-cycle response pulse.
module pbus_master
  import pbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PBUS_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   Clk,
  input  logic                   PBusResetN,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic                   CmdWrite,
  input  logic [PBUS_ADDR_W-1:0] CmdAddr,
  input  logic [PBUS_DATA_W-1:0] CmdData,
  output logic                   RspValid,
  output logic [PBUS_DATA_W-1:0] RspData,
  output logic                   RspTimeout,
  output logic [PBUS_ADDR_W-1:0] PBusAddr,
  output logic [PBUS_DATA_W-1:0] PBusDataOut,
  output logic                   PBusDataOE,
  input  logic [PBUS_DATA_W-1:0] PBusDataIn,
  output logic                   PBusRDN,
  output logic                   PBusWRN,
  input  logic                   PBusReadyN
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  pbus_state_e            state_q, state_d;
  logic                   isWrite_q, isWrite_d;
  logic [PBUS_ADDR_W-1:0] addr_q, addr_d;
  logic [PBUS_DATA_W-1:0] dataOut_q, dataOut_d;
  logic                   oe_q, oe_d;
  logic                   rdN_q, rdN_d;
  logic                   wrN_q, wrN_d;
  logic                   cmdReady_q, cmdReady_d;
  logic                   rspValid_q, rspValid_d;
  logic [PBUS_DATA_W-1:0] rspData_q, rspData_d;
  logic                   rspTimeout_q, rspTimeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   readyNSync;
  logic                   readyLow;
  logic [31:0]            cntWide;

  pbus_sync #(
    .STAGES (SYNC_STAGES)
  ) uReadySync (
    .clk_i  (Clk),
    .rstN_i (PBusResetN),
    .data_i (PBusReadyN),
    .data_o (readyNSync)
  );

  assign readyLow = ~readyNSync;
  assign cntWide  = 32'(cnt_q);

  always_comb begin
    state_d      = state_q;
    isWrite_d    = isWrite_q;
    addr_d       = addr_q;
    dataOut_d    = dataOut_q;
    rspData_d    = rspData_q;
    rspTimeout_d = rspTimeout_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid && cmdReady_q) begin
          isWrite_d    = CmdWrite;
          addr_d       = CmdAddr;
          dataOut_d    = CmdData;
          rspData_d    = '0;
          rspTimeout_d = 1'b0;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        // The first SYNC_STAGES strobe cycles still show ready as it was
        // before the strobe fell, so a stale low there must not complete.
        if (readyLow && (cntWide > 32'(SYNC_STAGES))) begin
          if (!isWrite_q) begin
            rspData_d = PBusDataIn;
          end
          rspTimeout_d = 1'b0;
          state_d      = ST_HOLD;
        end else if (cntWide == 32'(TIMEOUT_CYCLES)) begin
          rspTimeout_d = 1'b1;
          rspData_d    = '0;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rspTimeout_q || !readyLow) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus-side outputs are decoded from the next state and registered,
    // so strobes change only on clock edges and can never overlap.
    rdN_d      = !((state_d == ST_STROBE) && !isWrite_d);
    wrN_d      = !((state_d == ST_STROBE) && isWrite_d);
    oe_d       = isWrite_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                               (state_d == ST_HOLD));
    cmdReady_d = (state_d == ST_IDLE);
    rspValid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge Clk) begin
    if (!PBusResetN) begin
      state_q      <= ST_IDLE;
      isWrite_q    <= 1'b0;
      addr_q       <= '0;
      dataOut_q    <= '0;
      oe_q         <= 1'b0;
      rdN_q        <= 1'b1;
      wrN_q        <= 1'b1;
      cmdReady_q   <= 1'b0;
      rspValid_q   <= 1'b0;
      rspData_q    <= '0;
      rspTimeout_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      isWrite_q    <= isWrite_d;
      addr_q       <= addr_d;
      dataOut_q    <= dataOut_d;
      oe_q         <= oe_d;
      rdN_q        <= rdN_d;
      wrN_q        <= wrN_d;
      cmdReady_q   <= cmdReady_d;
      rspValid_q   <= rspValid_d;
      rspData_q    <= rspData_d;
      rspTimeout_q <= rspTimeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign CmdReady    = cmdReady_q;
  assign RspValid    = rspValid_q;
  assign RspData     = rspData_q;
  assign RspTimeout  = rspTimeout_q;
  assign PBusAddr    = addr_q;
  assign PBusDataOut = dataOut_q;
  assign PBusDataOE  = oe_q;
  assign PBusRDN     = rdN_q;
  assign PBusWRN     = wrN_q;

endmodule

// File: tb/tb_pbus_master.sv
// Self-checking bench for pbus_master: directed bus scenarios plus random
// transfers, acting as the bus responder and predicting each outcome.
module tb_pbus_master;
   import pbus_pkg::*;

   localparam int T      = 8;
   localparam int NS     = 2;
   localparam int NEVER  = -1;
   localparam int BUDGET = 120;

   logic                   Clk = 1'b0;
   logic                   PBusResetN = 1'b0;
   logic                   CmdValid = 1'b0;
   logic                   CmdReady;
   logic                   CmdWrite = 1'b0;
   logic [PBUS_ADDR_W-1:0] CmdAddr = '0;
   logic [PBUS_DATA_W-1:0] CmdData = '0;
   logic                   RspValid;
   logic [PBUS_DATA_W-1:0] RspData;
   logic                   RspTimeout;
   logic [PBUS_ADDR_W-1:0] PBusAddr;
   logic [PBUS_DATA_W-1:0] PBusDataOut;
   logic                   PBusDataOE;
   logic [PBUS_DATA_W-1:0] PBusDataIn = '0;
   logic                   PBusRDN;
   logic                   PBusWRN;
   logic                   PBusReadyN = 1'b1;

   int checks = 0;
   int fails  = 0;

   always #5 Clk = ~Clk;

   pbus_master #(
      .TIMEOUT_CYCLES (T),
      .SYNC_STAGES    (NS)
   ) dut (
      .Clk         (Clk),
      .PBusResetN  (PBusResetN),
      .CmdValid    (CmdValid),
      .CmdReady    (CmdReady),
      .CmdWrite    (CmdWrite),
      .CmdAddr     (CmdAddr),
      .CmdData     (CmdData),
      .RspValid    (RspValid),
      .RspData     (RspData),
      .RspTimeout  (RspTimeout),
      .PBusAddr    (PBusAddr),
      .PBusDataOut (PBusDataOut),
      .PBusDataOE  (PBusDataOE),
      .PBusDataIn  (PBusDataIn),
      .PBusRDN     (PBusRDN),
      .PBusWRN     (PBusWRN),
      .PBusReadyN  (PBusReadyN)
   );

   // Compares one observed value against its prediction and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one command, plays the responder (ready d cycles after the strobe
   // falls, released relDelay cycles after it rises) and checks the outcome.
   // The prediction: ready needs d+NS+1 strobe cycles to be seen, and wins
   // against the timeout when that is no more than T.
   task automatic applyStimulus(input string name, input bit wr, input logic [14:0] addr,
                                input logic [31:0] data, input logic [31:0] busData,
                                input int d, input int relDelay, input bit keepValid,
                                input bit prePulse, input bit expectImmediate);
      int waitCyc, cyc, strobeLen, oeLen, rspCnt, protoErr, readyDuring, relWait;
      int relCyc, holdCyc, respCyc, expLen;
      bit asserted, done, normal;
      logic [31:0] rspD, expData;
      logic rspT;
      waitCyc = 0; strobeLen = 0; oeLen = 0; rspCnt = 0; protoErr = 0;
      readyDuring = 0; relWait = 0; relCyc = -1; holdCyc = -1; respCyc = -1;
      asserted = 1'b0; done = 1'b0; rspD = '0; rspT = 1'b0;
      normal  = (d != NEVER) && (d + NS + 1 <= T);
      expLen  = normal ? d + NS + 1 : T;
      expData = (normal && !wr) ? busData : 32'h0;

      PBusReadyN = 1'b1;
      PBusDataIn = busData;
      CmdWrite   = wr;
      CmdAddr    = addr;
      CmdData    = data;
      CmdValid   = 1'b1;
      while (CmdReady !== 1'b1 && waitCyc < BUDGET) begin
         @(negedge Clk);
         waitCyc++;
      end
      checkOutput({name, "_accept_bound"}, 32'(waitCyc < BUDGET), 32'h1);
      if (expectImmediate) checkOutput({name, "_b2b_accept_wait"}, 32'(waitCyc), 32'h0);
      if (prePulse) PBusReadyN = 1'b0;
      @(negedge Clk);
      CmdValid = keepValid;
      cyc = 1;
      while (!done && cyc < BUDGET) begin
         if (!PBusRDN || !PBusWRN) begin
            strobeLen++;
            if (!PBusRDN && !PBusWRN) protoErr++;
            if (wr ? !PBusRDN : !PBusWRN) protoErr++;
            if (PBusAddr !== addr) protoErr++;
            if (wr && PBusDataOut !== data) protoErr++;
            if (!PBusWRN && PBusDataOE !== 1'b1) protoErr++;
         end else if (strobeLen > 0 && holdCyc < 0) begin
            holdCyc = cyc;
         end
         if (PBusDataOE === 1'b1) begin
            oeLen++;
            if (PBusAddr !== addr) protoErr++;
         end
         if (CmdReady !== 1'b0) readyDuring++;
         if (RspValid === 1'b1) begin
            rspCnt++;
            rspD    = RspData;
            rspT    = RspTimeout;
            respCyc = cyc;
            done    = 1'b1;
         end
         if (prePulse && cyc == 2) PBusReadyN = 1'b1;
         if (!asserted && d != NEVER && strobeLen == d + 1 && (!PBusRDN || !PBusWRN)) begin
            PBusReadyN = 1'b0;
            asserted   = 1'b1;
         end else if (asserted && PBusRDN && PBusWRN && PBusReadyN == 1'b0) begin
            if (relWait >= relDelay) begin
               PBusReadyN = 1'b1;
               relCyc     = cyc;
            end else begin
               relWait++;
            end
         end
         if (!done) begin
            @(negedge Clk);
            cyc++;
         end
      end
      checkOutput({name, "_rsp_count"}, 32'(rspCnt), 32'h1);
      checkOutput({name, "_strobe_len"}, 32'(strobeLen), 32'(expLen));
      checkOutput({name, "_oe_len"}, 32'(oeLen), wr ? 32'(expLen + 2) : 32'h0);
      checkOutput({name, "_rsp_data"}, rspD, expData);
      checkOutput({name, "_rsp_timeout"}, 32'(rspT), 32'(!normal));
      checkOutput({name, "_protocol_errs"}, 32'(protoErr), 32'h0);
      checkOutput({name, "_cmdready_busy"}, 32'(readyDuring), 32'h0);
      checkOutput({name, "_resp_gap"}, normal ? 32'(respCyc - relCyc) : 32'(respCyc - holdCyc),
                  normal ? 32'(NS + 1) : 32'h2);
      @(negedge Clk);
      checkOutput({name, "_rsp_pulse_len"}, 32'(RspValid), 32'h0);
      checkOutput({name, "_idle_ready"}, 32'(CmdReady), 32'h1);
   endtask

   initial begin
      int waitCyc, rspSeen, r, dRand, relRand;
      bit prevKeep, keep, wrRand;
      $display("[TB] pbus_master bench start");

      // Reset state is checked while reset is still held.
      PBusResetN = 1'b0;
      repeat (3) @(negedge Clk);
      checkOutput("rst_rdn", 32'(PBusRDN), 32'h1);
      checkOutput("rst_wrn", 32'(PBusWRN), 32'h1);
      checkOutput("rst_oe", 32'(PBusDataOE), 32'h0);
      checkOutput("rst_addr", 32'(PBusAddr), 32'h0);
      checkOutput("rst_dataout", PBusDataOut, 32'h0);
      checkOutput("rst_rspvalid", 32'(RspValid), 32'h0);
      checkOutput("rst_rspdata", RspData, 32'h0);
      checkOutput("rst_rsptimeout", 32'(RspTimeout), 32'h0);
      checkOutput("rst_cmdready", 32'(CmdReady), 32'h0);
      PBusResetN = 1'b1;
      @(negedge Clk);
      checkOutput("rst_release_cmdready", 32'(CmdReady), 32'h1);

      applyStimulus("read_basic", 1'b0, 15'h0040, 32'h0, 32'hDEADBEEF, 3, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus("write_top", 1'b1, 15'h7FFF, 32'h12345678, 32'hA5A5A5A5, 2, 1, 1'b0, 1'b0, 1'b0);
      applyStimulus("read_timeout", 1'b0, 15'h0123, 32'h0, 32'h55AA55AA, NEVER, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus("ready_at_limit", 1'b0, 15'h0200, 32'h0, 32'hCAFEBABE, T - NS - 1, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus("ready_past_limit", 1'b1, 15'h0201, 32'h0BADF00D, 32'h11111111, T - NS, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus("stale_ready", 1'b0, 15'h0300, 32'h0, 32'h22222222, NEVER, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus("b2b_first", 1'b0, 15'h0400, 32'h0, 32'h33333333, 1, 4, 1'b1, 1'b0, 1'b0);
      applyStimulus("b2b_second", 1'b1, 15'h0404, 32'h44444444, 32'h0, 0, 2, 1'b0, 1'b0, 1'b1);

      // Reset asserted mid-strobe aborts the write with no response.
      CmdWrite = 1'b1; CmdAddr = 15'h1234; CmdData = 32'hCAFEF00D; CmdValid = 1'b1;
      PBusReadyN = 1'b1;
      waitCyc = 0;
      while (CmdReady !== 1'b1 && waitCyc < BUDGET) begin @(negedge Clk); waitCyc++; end
      @(negedge Clk);
      CmdValid = 1'b0;
      while (PBusWRN !== 1'b0 && waitCyc < BUDGET) begin @(negedge Clk); waitCyc++; end
      checkOutput("midrst_reach_strobe", 32'(waitCyc < BUDGET), 32'h1);
      @(negedge Clk);
      checkOutput("midrst_oe_before", 32'(PBusDataOE), 32'h1);
      PBusResetN = 1'b0;
      @(negedge Clk);
      checkOutput("midrst_rdn", 32'(PBusRDN), 32'h1);
      checkOutput("midrst_wrn", 32'(PBusWRN), 32'h1);
      checkOutput("midrst_oe", 32'(PBusDataOE), 32'h0);
      checkOutput("midrst_rspvalid", 32'(RspValid), 32'h0);
      checkOutput("midrst_cmdready", 32'(CmdReady), 32'h0);
      PBusResetN = 1'b1;
      @(negedge Clk);
      checkOutput("midrst_release_cmdready", 32'(CmdReady), 32'h1);
      rspSeen = 0;
      for (int i = 0; i < 10; i++) begin
         if (RspValid === 1'b1) rspSeen++;
         @(negedge Clk);
      end
      checkOutput("midrst_no_rsp", 32'(rspSeen), 32'h0);

      // Random transfers, some back-to-back with CmdValid held high.
      prevKeep = 1'b0;
      for (int n = 0; n < 24; n++) begin
         r       = int'($urandom_range(0, 7));
         dRand   = (r == 7) ? NEVER : r;
         relRand = int'($urandom_range(0, 3));
         wrRand  = 1'($urandom_range(0, 1));
         keep    = 1'($urandom_range(0, 1));
         applyStimulus($sformatf("rand%0d", n), wrRand, 15'($urandom), $urandom, $urandom,
                       dRand, relRand, keep, 1'b0, prevKeep);
         prevKeep = keep;
      end
      CmdValid = 1'b0;
      repeat (2) @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
